load_store_unit: RTL and testbench

Memory-access stage that sits directly downstream of execute. It takes a single-word load/store or a block (multiple-register) transfer from execute and drives the core's memory bus (addr, wdata, write, size, prot, trans). The bus is shared with instruction fetch and arbitrated outside this block. For loads it returns register writeback beats to the writeback path. Memory is word-addressed, and read data appears on rdata one cycle after the address phase.

---
 rtl/load_store_unit.sv | 156 +++++++++++++++
 tb/tb_load_store_unit.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Memory-access stage: single or block load/store onto the shared core bus,
// with pipelined data phase and register writeback for loads.
module load_store_unit #(
   parameter int DATA_W = 32,
   parameter int NREG   = 16
) (
   input  logic                     clk,
   input  logic                     n_reset,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_load,
   input  logic                     req_multi,
   input  logic [DATA_W-1:0]        req_addr,
   input  logic [$clog2(NREG)-1:0]  req_rd,
   input  logic [NREG-1:0]          req_reglist,
   output logic [$clog2(NREG)-1:0]  st_rr_i,
   input  logic [DATA_W-1:0]        st_rr_data,
   output logic [DATA_W-1:0]        addr,
   output logic [DATA_W-1:0]        wdata,
   input  logic [DATA_W-1:0]        rdata,
   input  logic                     abort,
   output logic                     write,
   output logic [1:0]               size,
   output logic [1:0]               prot,
   output logic [1:0]               trans,
   output logic                     wb_valid,
   output logic [$clog2(NREG)-1:0]  wb_reg,
   output logic [DATA_W-1:0]        wb_data,
   output logic                     done,
   output logic                     err
);

   localparam int RI_W = $clog2(NREG);

   typedef enum logic [1:0] {IDLE, XFER, TAIL} state_t;

   state_t            state, state_nx;
   logic [DATA_W-1:0] addr_q;
   logic [NREG-1:0]   list_q, list_nx, beats_in;
   logic              load_q, first_q;
   logic              ph_valid;
   logic [RI_W-1:0]   ph_reg;
   logic [RI_W-1:0]   cur;
   logic              abort_hit;

   assign size = 2'b10;
   assign prot = 2'b11;
   assign addr = addr_q;

   assign beats_in  = req_multi ? req_reglist : ({{(NREG-1){1'b0}}, 1'b1} << req_rd);
   // Clearing the lowest set bit yields the remaining list after this beat.
   assign list_nx   = list_q & (list_q - NREG'(1));
   assign abort_hit = ph_valid & abort;

   always_comb begin
      cur = '0;
      for (int unsigned i = NREG; i > 0; i--) begin
         if (list_q[i-1]) cur = RI_W'(i - 1);
      end
   end

   always_ff @(posedge clk) begin
      if (!n_reset) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      req_ready = 1'b0;
      trans     = 2'b00;
      write     = 1'b0;
      st_rr_i   = '0;
      wdata     = '0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid && beats_in != '0) state_nx = XFER;
         end
         XFER: begin
            trans = first_q ? 2'b10 : 2'b11;
            write = ~load_q;
            if (!load_q) begin
               st_rr_i = cur;
               wdata   = st_rr_data;
            end
            if (abort_hit)            state_nx = IDLE;
            else if (list_nx == '0)   state_nx = TAIL;
         end
         TAIL:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         addr_q   <= '0;
         list_q   <= '0;
         load_q   <= 1'b0;
         first_q  <= 1'b0;
         ph_valid <= 1'b0;
         ph_reg   <= '0;
         wb_valid <= 1'b0;
         wb_reg   <= '0;
         wb_data  <= '0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         wb_valid <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  addr_q  <= req_addr;
                  load_q  <= req_load;
                  list_q  <= beats_in;
                  first_q <= 1'b1;
                  if (beats_in == '0) done <= 1'b1;
               end
            end
            XFER: begin
               if (abort_hit) begin
                  done     <= 1'b1;
                  err      <= 1'b1;
                  ph_valid <= 1'b0;
               end else begin
                  // Data phase of the previous beat overlaps this address phase.
                  wb_valid <= ph_valid & load_q;
                  if (ph_valid) begin
                     wb_reg  <= ph_reg;
                     wb_data <= rdata;
                  end
                  list_q   <= list_nx;
                  addr_q   <= addr_q + DATA_W'(1);
                  first_q  <= 1'b0;
                  ph_valid <= 1'b1;
                  ph_reg   <= cur;
               end
            end
            TAIL: begin
               ph_valid <= 1'b0;
               done     <= 1'b1;
               if (abort_hit) begin
                  err <= 1'b1;
               end else begin
                  wb_valid <= ph_valid & load_q;
                  wb_reg   <= ph_reg;
                  wb_data  <= rdata;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: small bus memory and register file model,
// per-cycle inline checks against hand-computed expectations.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        n_reset;
   logic        req_valid, req_ready, req_load, req_multi;
   logic [31:0] req_addr;
   logic [3:0]  req_rd;
   logic [15:0] req_reglist;
   logic [3:0]  st_rr_i;
   logic [31:0] st_rr_data;
   logic [31:0] addr, wdata, rdata;
   logic        abort, write;
   logic [1:0]  size, prot, trans;
   logic        wb_valid;
   logic [3:0]  wb_reg;
   logic [31:0] wb_data;
   logic        done, err;

   logic [31:0] mem  [0:15];
   logic [31:0] regs [0:15];

   int vectors = 0;
   int miscompares = 0;

   load_store_unit #(.DATA_W(32), .NREG(16)) dut (
      .clk(clk), .n_reset(n_reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
      .req_multi(req_multi), .req_addr(req_addr), .req_rd(req_rd),
      .req_reglist(req_reglist), .st_rr_i(st_rr_i), .st_rr_data(st_rr_data),
      .addr(addr), .wdata(wdata), .rdata(rdata), .abort(abort), .write(write),
      .size(size), .prot(prot), .trans(trans), .wb_valid(wb_valid),
      .wb_reg(wb_reg), .wb_data(wb_data), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   assign st_rr_data = regs[st_rr_i];

   // Bus memory, aliased on addr[3:0]; read data lands the cycle after the address phase.
   always @(posedge clk) begin
      if (trans[1] && !write) rdata <= mem[addr[3:0]];
      if (trans[1] && write)  mem[addr[3:0]] <= wdata;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic ld, input logic multi, input logic [31:0] a,
                        input logic [3:0] rd, input logic [15:0] list);
      req_valid   = 1'b1;
      req_load    = ld;
      req_multi   = multi;
      req_addr    = a;
      req_rd      = rd;
      req_reglist = list;
      tick();
      req_valid   = 1'b0;
   endtask

   task automatic test_reset();
      n_reset = 1'b0;
      tick();
      tick();
      vectors++;
      if (trans !== 2'b00 || write !== 1'b0 || addr !== 32'h0 || wdata !== 32'h0 || st_rr_i !== 4'h0) begin
         miscompares++;
         $display("FAIL reset_bus: trans=%b write=%b addr=%h wdata=%h st_rr_i=%h expected 00 0 0 0 0",
                  trans, write, addr, wdata, st_rr_i);
      end
      vectors++;
      if (wb_valid !== 1'b0 || wb_reg !== 4'h0 || wb_data !== 32'h0 || done !== 1'b0 || err !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_wb: wb_valid=%b wb_reg=%h wb_data=%h done=%b err=%b expected all 0",
                  wb_valid, wb_reg, wb_data, done, err);
      end
      vectors++;
      if (req_ready !== 1'b1 || size !== 2'b10 || prot !== 2'b11) begin
         miscompares++;
         $display("FAIL reset_const: req_ready=%b size=%b prot=%b expected 1 10 11", req_ready, size, prot);
      end
      n_reset = 1'b1;
      tick();
   endtask

   task automatic test_single_load();
      mem[0] = 32'hDEADBEEF;
      vectors++;
      if (req_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL sl_ready: got %b expected 1", req_ready);
      end
      issue(1'b1, 1'b0, 32'h40, 4'd3, 16'h0);
      vectors++;
      if (trans !== 2'b10 || addr !== 32'h40 || write !== 1'b0 || req_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL sl_c0: trans=%b addr=%h write=%b ready=%b expected 10 40 0 0", trans, addr, write, req_ready);
      end
      tick();
      vectors++;
      if (trans !== 2'b00 || wb_valid !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL sl_c1: trans=%b wb_valid=%b done=%b expected 00 0 0", trans, wb_valid, done);
      end
      tick();
      vectors++;
      if (wb_valid !== 1'b1 || wb_reg !== 4'd3 || wb_data !== 32'hDEADBEEF || done !== 1'b1 || err !== 1'b0
          || req_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL sl_c2: wb=%b reg=%0d data=%h done=%b err=%b ready=%b expected 1 3 deadbeef 1 0 1",
                  wb_valid, wb_reg, wb_data, done, err, req_ready);
      end
      tick();
      vectors++;
      if (wb_valid !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL sl_pulse: wb_valid=%b done=%b expected 0 0", wb_valid, done);
      end
   endtask

   task automatic test_block_load();
      logic [3:0]  er [4] = '{4'd0, 4'd2, 4'd4, 4'd15};
      logic [31:0] ed [4] = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};
      logic [1:0]  et;
      for (int i = 0; i < 4; i++) mem[i] = ed[i];
      issue(1'b1, 1'b1, 32'h100, 4'd0, 16'h8015);
      for (int c = 0; c < 6; c++) begin
         et = (c == 0) ? 2'b10 : (c < 4) ? 2'b11 : 2'b00;
         vectors++;
         if (trans !== et) begin
            miscompares++;
            $display("FAIL bl_trans c=%0d: got %b expected %b", c, trans, et);
         end
         if (c < 4) begin
            vectors++;
            if (addr !== 32'h100 + 32'(c)) begin
               miscompares++;
               $display("FAIL bl_addr c=%0d: got %h expected %h", c, addr, 32'h100 + 32'(c));
            end
         end
         vectors++;
         if (wb_valid !== (c >= 2)) begin
            miscompares++;
            $display("FAIL bl_wbv c=%0d: got %b expected %b", c, wb_valid, (c >= 2));
         end
         if (c >= 2) begin
            vectors++;
            if (wb_reg !== er[c-2] || wb_data !== ed[c-2]) begin
               miscompares++;
               $display("FAIL bl_wb c=%0d: got (%0d,%h) expected (%0d,%h)", c, wb_reg, wb_data, er[c-2], ed[c-2]);
            end
         end
         vectors++;
         if (done !== (c == 5) || err !== 1'b0) begin
            miscompares++;
            $display("FAIL bl_done c=%0d: done=%b err=%b expected %b 0", c, done, err, (c == 5));
         end
         tick();
      end
   endtask

   task automatic test_block_store();
      regs[1] = 32'h11;
      regs[2] = 32'h22;
      mem[0]  = 32'h0;
      mem[1]  = 32'h0;
      issue(1'b0, 1'b1, 32'h200, 4'd0, 16'h0006);
      vectors++;
      if (trans !== 2'b10 || write !== 1'b1 || st_rr_i !== 4'd1 || wdata !== 32'h11 || addr !== 32'h200) begin
         miscompares++;
         $display("FAIL bs_c0: trans=%b write=%b rr=%0d wdata=%h addr=%h expected 10 1 1 11 200",
                  trans, write, st_rr_i, wdata, addr);
      end
      tick();
      vectors++;
      if (trans !== 2'b11 || write !== 1'b1 || st_rr_i !== 4'd2 || wdata !== 32'h22 || addr !== 32'h201) begin
         miscompares++;
         $display("FAIL bs_c1: trans=%b write=%b rr=%0d wdata=%h addr=%h expected 11 1 2 22 201",
                  trans, write, st_rr_i, wdata, addr);
      end
      tick();
      vectors++;
      if (trans !== 2'b00 || write !== 1'b0 || wb_valid !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL bs_c2: trans=%b write=%b wb=%b done=%b expected 00 0 0 0", trans, write, wb_valid, done);
      end
      tick();
      vectors++;
      if (done !== 1'b1 || err !== 1'b0 || wb_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL bs_c3: done=%b err=%b wb=%b expected 1 0 0", done, err, wb_valid);
      end
      vectors++;
      if (mem[0] !== 32'h11 || mem[1] !== 32'h22) begin
         miscompares++;
         $display("FAIL bs_mem: got %h %h expected 11 22", mem[0], mem[1]);
      end
      tick();
   endtask

   task automatic test_abort();
      for (int i = 0; i < 4; i++) mem[i] = 32'h5000 + 32'(i);
      issue(1'b1, 1'b1, 32'h100, 4'd0, 16'h000F);
      vectors++;
      if (trans !== 2'b10 || addr !== 32'h100) begin
         miscompares++;
         $display("FAIL ab_c0: trans=%b addr=%h expected 10 100", trans, addr);
      end
      tick();
      vectors++;
      if (trans !== 2'b11 || addr !== 32'h101 || wb_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL ab_c1: trans=%b addr=%h wb=%b expected 11 101 0", trans, addr, wb_valid);
      end
      tick();
      vectors++;
      if (trans !== 2'b11 || addr !== 32'h102 || wb_valid !== 1'b1 || wb_reg !== 4'd0 || wb_data !== 32'h5000) begin
         miscompares++;
         $display("FAIL ab_c2: trans=%b addr=%h wb=%b reg=%0d data=%h expected 11 102 1 0 5000",
                  trans, addr, wb_valid, wb_reg, wb_data);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      vectors++;
      if (done !== 1'b1 || err !== 1'b1 || trans !== 2'b00 || wb_valid !== 1'b0 || req_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL ab_c3: done=%b err=%b trans=%b wb=%b ready=%b expected 1 1 00 0 1",
                  done, err, trans, wb_valid, req_ready);
      end
      tick();
      vectors++;
      if (trans !== 2'b00 || wb_valid !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL ab_c4: trans=%b wb=%b done=%b expected 00 0 0", trans, wb_valid, done);
      end
   endtask

   task automatic test_reset_mid();
      issue(1'b1, 1'b1, 32'h100, 4'd0, 16'h000F);
      tick();
      tick();
      vectors++;
      if (addr !== 32'h102 || trans !== 2'b11) begin
         miscompares++;
         $display("FAIL rm_c2: addr=%h trans=%b expected 102 11", addr, trans);
      end
      n_reset = 1'b0;
      tick();
      vectors++;
      if (trans !== 2'b00 || wb_valid !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL rm_rst: trans=%b wb=%b done=%b expected 00 0 0", trans, wb_valid, done);
      end
      n_reset = 1'b1;
      tick();
      vectors++;
      if (req_ready !== 1'b1 || done !== 1'b0 || wb_valid !== 1'b0 || trans !== 2'b00) begin
         miscompares++;
         $display("FAIL rm_idle: ready=%b done=%b wb=%b trans=%b expected 1 0 0 00", req_ready, done, wb_valid, trans);
      end
      mem[5] = 32'h12345678;
      issue(1'b1, 1'b0, 32'h45, 4'd7, 16'h0);
      vectors++;
      if (trans !== 2'b10 || addr !== 32'h45) begin
         miscompares++;
         $display("FAIL rm_new_c0: trans=%b addr=%h expected 10 45", trans, addr);
      end
      tick();
      tick();
      vectors++;
      if (wb_valid !== 1'b1 || wb_reg !== 4'd7 || wb_data !== 32'h12345678 || done !== 1'b1 || err !== 1'b0) begin
         miscompares++;
         $display("FAIL rm_new_c2: wb=%b reg=%0d data=%h done=%b err=%b expected 1 7 12345678 1 0",
                  wb_valid, wb_reg, wb_data, done, err);
      end
      tick();
   endtask

   task automatic test_empty_list();
      issue(1'b1, 1'b1, 32'h300, 4'd0, 16'h0000);
      vectors++;
      if (trans !== 2'b00 || done !== 1'b1 || err !== 1'b0 || wb_valid !== 1'b0 || req_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL em_c0: trans=%b done=%b err=%b wb=%b ready=%b expected 00 1 0 0 1",
                  trans, done, err, wb_valid, req_ready);
      end
      tick();
      vectors++;
      if (trans !== 2'b00 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL em_c1: trans=%b done=%b expected 00 0", trans, done);
      end
   endtask

   task automatic test_back_to_back();
      req_valid   = 1'b1;
      req_load    = 1'b1;
      req_multi   = 1'b0;
      req_addr    = 32'h41;
      req_rd      = 4'd5;
      req_reglist = 16'h0;
      tick();
      req_addr = 32'h50;
      vectors++;
      if (trans !== 2'b10 || addr !== 32'h41 || req_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL bb_c0: trans=%b addr=%h ready=%b expected 10 41 0", trans, addr, req_ready);
      end
      tick();
      vectors++;
      if (trans !== 2'b00 || req_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL bb_c1: trans=%b ready=%b expected 00 0", trans, req_ready);
      end
      tick();
      vectors++;
      if (trans !== 2'b00 || req_ready !== 1'b1 || done !== 1'b1) begin
         miscompares++;
         $display("FAIL bb_c2: trans=%b ready=%b done=%b expected 00 1 1", trans, req_ready, done);
      end
      tick();
      req_valid = 1'b0;
      vectors++;
      if (trans !== 2'b10 || addr !== 32'h50) begin
         miscompares++;
         $display("FAIL bb_c3: trans=%b addr=%h expected 10 50", trans, addr);
      end
      tick();
      tick();
      vectors++;
      if (done !== 1'b1 || wb_valid !== 1'b1 || wb_reg !== 4'd5) begin
         miscompares++;
         $display("FAIL bb_c5: done=%b wb=%b reg=%0d expected 1 1 5", done, wb_valid, wb_reg);
      end
      tick();
   endtask

   task automatic test_addr_wrap();
      mem[15] = 32'hF0F0F0F0;
      mem[0]  = 32'h0A0A0A0A;
      issue(1'b1, 1'b1, 32'hFFFFFFFF, 4'd0, 16'h0003);
      vectors++;
      if (trans !== 2'b10 || addr !== 32'hFFFFFFFF) begin
         miscompares++;
         $display("FAIL wr_c0: trans=%b addr=%h expected 10 ffffffff", trans, addr);
      end
      tick();
      vectors++;
      if (trans !== 2'b11 || addr !== 32'h00000000) begin
         miscompares++;
         $display("FAIL wr_c1: trans=%b addr=%h expected 11 00000000", trans, addr);
      end
      tick();
      vectors++;
      if (trans !== 2'b00 || wb_valid !== 1'b1 || wb_reg !== 4'd0 || wb_data !== 32'hF0F0F0F0) begin
         miscompares++;
         $display("FAIL wr_c2: trans=%b wb=%b reg=%0d data=%h expected 00 1 0 f0f0f0f0",
                  trans, wb_valid, wb_reg, wb_data);
      end
      tick();
      vectors++;
      if (wb_valid !== 1'b1 || wb_reg !== 4'd1 || wb_data !== 32'h0A0A0A0A || done !== 1'b1 || err !== 1'b0) begin
         miscompares++;
         $display("FAIL wr_c3: wb=%b reg=%0d data=%h done=%b err=%b expected 1 1 0a0a0a0a 1 0",
                  wb_valid, wb_reg, wb_data, done, err);
      end
      tick();
   endtask

   initial begin
      n_reset     = 1'b0;
      req_valid   = 1'b0;
      req_load    = 1'b0;
      req_multi   = 1'b0;
      req_addr    = 32'h0;
      req_rd      = 4'h0;
      req_reglist = 16'h0;
      abort       = 1'b0;
      rdata       = 32'h0;
      for (int i = 0; i < 16; i++) begin
         mem[i]  = 32'h0;
         regs[i] = 32'h0;
      end
      #1;
      test_reset();
      test_single_load();
      test_block_load();
      test_block_store();
      test_abort();
      test_reset_mid();
      test_empty_list();
      test_back_to_back();
      test_addr_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
